// File: rtl/i2c_types_pkg.sv
// Shared I2C types: byte-level command encoding, ACK/NACK bit values, the
// bit-level command set used between the byte FSM and the bit controller, and
// the per-phase SCL/SDA drive table.
package i2c_types_pkg;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2c_cmd_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [1:0] {
    BIT_START,
    BIT_RSTART,
    BIT_STOP,
    BIT_DATA
  } bit_cmd_t;

  // Returns {scl, sda} driven during the given phase (1 = released).
  function automatic logic [1:0] phase_drive(bit_cmd_t cmd, logic [1:0] phase, logic tx);
    logic [1:0] drv;
    drv = 2'b11;
    case (cmd)
      BIT_START: begin
        case (phase)
          2'd0:    drv = 2'b11;
          2'd1:    drv = 2'b10;
          2'd2:    drv = 2'b10;
          default: drv = 2'b00;
        endcase
      end
      BIT_RSTART: begin
        case (phase)
          2'd0:    drv = 2'b01;
          2'd1:    drv = 2'b11;
          2'd2:    drv = 2'b10;
          default: drv = 2'b00;
        endcase
      end
      BIT_STOP: begin
        case (phase)
          2'd0:    drv = 2'b00;
          2'd1:    drv = 2'b10;
          default: drv = 2'b11;
        endcase
      end
      default: drv = {(phase == 2'd1) || (phase == 2'd2), tx};
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/i2c_master_bit_ctrl.sv
// I2C master bit controller: quarter-period divider, 4-phase sequencer and
// open-drain SCL/SDA drive for START, repeated START, STOP and data bits.
// Optional macro I2C_CLK_STRETCH_EN: high-SCL phases wait for scl_i high.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   bit_valid, bit_cmd   next bit operation; taken when idle or on bit_done
//   bit_tx, bit_arb      data bit value (1 = release) and arbitration check enable
//   bit_done             high in the last cycle of the current bit operation
//   bit_rx               SDA sampled at the end of p2
//   arb_lost             high in the last cycle of p2 when a released SDA reads 0
//   scl_i, sda_i         sampled bus lines
//   scl_o, sda_o         line drives (0 = pull low, 1 = release)
module i2c_master_bit_ctrl
  import i2c_types_pkg::*;
#(
  parameter int unsigned QTR_PERIOD = 250
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     bit_valid,
  input  bit_cmd_t bit_cmd,
  input  logic     bit_tx,
  input  logic     bit_arb,
  output logic     bit_done,
  output logic     bit_rx,
  output logic     arb_lost,
  input  logic     scl_i,
  input  logic     sda_i,
  output logic     scl_o,
  output logic     sda_o
);

  localparam logic [15:0] Term = 16'(QTR_PERIOD - 1);

  logic        active_q;
  bit_cmd_t    cmd_q;
  logic        tx_q, arb_q, rx_q, scl_q, sda_q;
  logic [1:0]  phase_q;
  logic [15:0] cnt_q;
  logic        at_term, phase_end;

  assign at_term = active_q && (cnt_q == Term);

`ifdef I2C_CLK_STRETCH_EN
  // Divider parks at terminal count while a slave holds SCL low.
  assign phase_end = at_term && (!scl_q || scl_i);
`else
  assign phase_end = at_term;
  logic unused_scl;
  assign unused_scl = scl_i;
`endif

  assign bit_done = phase_end && (phase_q == 2'd3);
  assign arb_lost = phase_end && (phase_q == 2'd2) && arb_q && tx_q && !sda_i;
  assign bit_rx   = rx_q;
  assign scl_o    = scl_q;
  assign sda_o    = sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cmd_q    <= BIT_START;
      tx_q     <= 1'b1;
      arb_q    <= 1'b0;
      rx_q     <= 1'b0;
      phase_q  <= 2'd0;
      cnt_q    <= 16'd0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else if (!active_q || bit_done) begin
      // Next bit starts on the edge that ends the previous one; when idle the
      // lines keep their last drive (SCL stays low while the bus is owned).
      if (bit_valid) begin
        active_q       <= 1'b1;
        cmd_q          <= bit_cmd;
        tx_q           <= bit_tx;
        arb_q          <= bit_arb;
        phase_q        <= 2'd0;
        cnt_q          <= 16'd0;
        {scl_q, sda_q} <= phase_drive(bit_cmd, 2'd0, bit_tx);
      end else begin
        active_q <= 1'b0;
      end
    end else if (arb_lost) begin
      active_q <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else if (phase_end) begin
      phase_q        <= phase_q + 2'd1;
      cnt_q          <= 16'd0;
      {scl_q, sda_q} <= phase_drive(cmd_q, phase_q + 2'd1, tx_q);
      if (phase_q == 2'd2) rx_q <= sda_i;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller: accepts START/STOP/WRITE/READ_ACK/READ_NAK on a
// valid/ready interface, sequences them through i2c_master_bit_ctrl, and
// reports rx data, ACK, error and completion.
// Optional macro I2C_CLK_STRETCH_EN (handled in the bit controller).
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   cmd_i/cmd_valid_i/cmd_ready_o  command handshake (cmd_i encoded as i2c_cmd_t)
//   tx_data_i                  WRITE byte, sampled on accept
//   rx_data_o                  byte captured by READ_*
//   ack_o, err_o, done_o       WRITE ACK bit, error flag, completion pulse
//   busy_o                     bus owned between START and STOP
//   scl_i, sda_i, scl_o, sda_o bus sample and open-drain drive
module i2c_master_byte_ctrl
  import i2c_types_pkg::*;
#(
  parameter int unsigned QTR_PERIOD     = 250,
  parameter int unsigned I2C_DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [2:0]                cmd_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      done_o,
  output logic                      busy_o,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o
);

  localparam int unsigned CntW = $clog2(I2C_DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(I2C_DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START_PH, RSTART_PH, STOP_PH, DATA_BIT, ACK_BIT, DONE} state_t;

  state_t                    state_q;
  logic                      busy_q, ready_q, done_q, err_q, ack_q, is_rd_q, nak_q;
  logic [I2C_DATA_WIDTH-1:0] rx_q, data_q;
  logic [CntW-1:0]           bit_cnt_q;

  logic     accept, legal, bit_valid, bit_tx, bit_arb, bit_done, bit_rx, arb_lost;
  bit_cmd_t bit_cmd;

  assign accept      = cmd_valid_i && ready_q;
  assign cmd_ready_o = ready_q;
  assign rx_data_o   = rx_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

  // Bit requests go out combinationally so the first phase starts on the
  // accept edge and consecutive bits run without gaps.
  always_comb begin
    legal     = 1'b0;
    bit_valid = 1'b0;
    bit_cmd   = BIT_DATA;
    bit_tx    = 1'b1;
    bit_arb   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_i)
            CMD_START: begin
              legal   = 1'b1;
              bit_cmd = busy_q ? BIT_RSTART : BIT_START;
            end
            CMD_STOP: begin
              legal   = busy_q;
              bit_cmd = BIT_STOP;
            end
            CMD_WRITE: begin
              legal   = busy_q;
              bit_tx  = tx_data_i[I2C_DATA_WIDTH-1];
              bit_arb = 1'b1;
            end
            CMD_READ_ACK, CMD_READ_NAK: legal = busy_q;
            default: legal = 1'b0;
          endcase
        end
        bit_valid = legal;
      end
      DATA_BIT: begin
        if (bit_done) begin
          bit_valid = 1'b1;
          if (bit_cnt_q == LastBit) begin
            bit_tx = is_rd_q ? nak_q : 1'b1;
          end else begin
            bit_tx  = is_rd_q ? 1'b1 : data_q[I2C_DATA_WIDTH-2];
            bit_arb = !is_rd_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      is_rd_q   <= 1'b0;
      nak_q     <= 1'b0;
      rx_q      <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            data_q    <= tx_data_i;
            bit_cnt_q <= '0;
            is_rd_q   <= (cmd_i == CMD_READ_ACK) || (cmd_i == CMD_READ_NAK);
            nak_q     <= (cmd_i == CMD_READ_NAK);
            if (!legal) begin
              state_q <= DONE;
            end else begin
              case (cmd_i)
                CMD_START: state_q <= busy_q ? RSTART_PH : START_PH;
                CMD_STOP:  state_q <= STOP_PH;
                default:   state_q <= DATA_BIT;
              endcase
            end
          end
        end
        START_PH, RSTART_PH, STOP_PH: begin
          if (bit_done) begin
            busy_q  <= (state_q != STOP_PH);
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        DATA_BIT: begin
          if (arb_lost) begin
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (bit_done) begin
            // Same shift serves both directions: WRITE shifts out, READ shifts in.
            data_q    <= {data_q[I2C_DATA_WIDTH-2:0], bit_rx};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) state_q <= ACK_BIT;
          end
        end
        ACK_BIT: begin
          if (bit_done) begin
            if (is_rd_q) rx_q <= data_q;
            else         ack_q <= bit_rx;
            err_q   <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        DONE: begin
          err_q   <= 1'b1;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  i2c_master_bit_ctrl #(
    .QTR_PERIOD(QTR_PERIOD)
  ) u_bit_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bit_valid(bit_valid),
    .bit_cmd  (bit_cmd),
    .bit_tx   (bit_tx),
    .bit_arb  (bit_arb),
    .bit_done (bit_done),
    .bit_rx   (bit_rx),
    .arb_lost (arb_lost),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_o    (scl_o),
    .sda_o    (sda_o)
  );

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for i2c_master_byte_ctrl with QTR_PERIOD=4 and a small
// scripted slave on the wired-AND bus.
module tb_i2c_master_byte_ctrl;
  import i2c_types_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] cmd_i = 3'd0;
  logic       cmd_valid_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       cmd_ready_o, ack_o, err_o, done_o, busy_o, scl_o, sda_o;
  logic [7:0] rx_data_o;
  logic       scl_i, sda_i;

  // Bus model: slave drives per-bit values indexed by SCL falls since command issue.
  logic       stretch = 1'b0, force_low = 1'b0, slave_en = 1'b0;
  logic [8:0] slave_bits = 9'h1FF;
  int         fall_total = 0, fall_base = 0, rise_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic [15:0] rise_bits = 16'h0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         slave_idx;
  logic       slave_sda;

  assign slave_idx = fall_total - fall_base;
  assign slave_sda = (slave_en && slave_idx >= 0 && slave_idx <= 8) ? slave_bits[8 - slave_idx]
                                                                    : 1'b1;
  assign scl_i = scl_o & ~stretch;
  assign sda_i = sda_o & slave_sda & ~force_low;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    scl_p <= scl_i;
    sda_p <= sda_i;
    if (scl_i && !scl_p) begin
      rise_bits <= {rise_bits[14:0], sda_i};
      rise_cnt  <= rise_cnt + 1;
    end
    if (!scl_i && scl_p) fall_total <= fall_total + 1;
    if (scl_p && scl_i && sda_p && !sda_i) start_cnt <= start_cnt + 1;
    if (scl_p && scl_i && !sda_p && sda_i) stop_cnt <= stop_cnt + 1;
  end

  i2c_master_byte_ctrl #(
    .QTR_PERIOD    (4),
    .I2C_DATA_WIDTH(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_i      (cmd_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .tx_data_i  (tx_data_i),
    .rx_data_o  (rx_data_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_o      (scl_o),
    .sda_o      (sda_o)
  );

  int         total = 0, bad = 0;
  logic [1:0] samp [0:63];
  logic       rdy_bad, bus_low;

  // Issues one command and waits (bounded) for done_o; cyc = edges from accept to done.
  task automatic do_cmd(input logic [2:0] c, input logic [7:0] d, output int cyc);
    @(negedge clk_i);
    fall_base   = fall_total;
    cmd_i       = c;
    tx_data_i   = d;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cyc     = 0;
    rdy_bad = (cmd_ready_o !== 1'b0);
    bus_low = (scl_o !== 1'b1) || (sda_o !== 1'b1);
    samp[0] = {scl_o, sda_o};
    while (done_o !== 1'b1 && cyc < 2000) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (cyc < 64) samp[cyc] = {scl_o, sda_o};
      if (done_o !== 1'b1 && cmd_ready_o !== 1'b0) rdy_bad = 1'b1;
      if (scl_o !== 1'b1 || sda_o !== 1'b1) bus_low = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({scl_o, sda_o, cmd_ready_o, done_o, err_o, ack_o, busy_o} !== 7'b1110000) begin
      bad++;
      $display("FAIL reset_outs: got %b want 1110000",
               {scl_o, sda_o, cmd_ready_o, done_o, err_o, ack_o, busy_o});
    end
    total++;
    if (rx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx: got %h want 00", rx_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_illegal();
    int cyc;
    logic [2:0] cmds [3];
    cmds[0] = CMD_WRITE;
    cmds[1] = CMD_STOP;
    cmds[2] = 3'd6;
    for (int i = 0; i < 3; i++) begin
      do_cmd(cmds[i], 8'hA5, cyc);
      total++;
      if (cyc !== 1 || err_o !== 1'b1 || bus_low !== 1'b0 || cmd_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL illegal_%0d: cyc=%0d err=%b bus_low=%b rdy=%b want 1 1 0 1",
                 i, cyc, err_o, bus_low, cmd_ready_o);
      end
    end
  endtask

  task automatic test_write_ack();
    int cyc, s0;
    s0 = start_cnt;
    do_cmd(CMD_START, 8'h00, cyc);
    total++;
    if (cyc !== 16 || busy_o !== 1'b1 || err_o !== 1'b0 || start_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL start: cyc=%0d busy=%b err=%b starts=%0d want 16 1 0 1",
               cyc, busy_o, err_o, start_cnt - s0);
    end
    total++;
    if ({samp[0], samp[4], samp[8], samp[12]} !== 8'b11101000) begin
      bad++;
      $display("FAIL start_wave: got %b want 11101000", {samp[0], samp[4], samp[8], samp[12]});
    end
    slave_en   = 1'b1;
    slave_bits = 9'h1FE;
    s0 = rise_cnt;
    do_cmd(CMD_WRITE, 8'h44, cyc);
    slave_en = 1'b0;
    total++;
    if (cyc !== 144 || rdy_bad !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL write_timing: cyc=%0d rdy_bad=%b rdy=%b want 144 0 1",
               cyc, rdy_bad, cmd_ready_o);
    end
    total++;
    if (rise_bits[8:0] !== 9'h088 || rise_cnt - s0 !== 9) begin
      bad++;
      $display("FAIL write_bits: got %h rises=%0d want 088 9", rise_bits[8:0], rise_cnt - s0);
    end
    total++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL write_ack: ack=%b err=%b busy=%b want 0 0 1", ack_o, err_o, busy_o);
    end
  endtask

  task automatic test_write_nack_stop();
    int cyc, s0;
    do_cmd(CMD_WRITE, 8'h90, cyc);
    total++;
    if (cyc !== 144 || ack_o !== 1'b1 || err_o !== 1'b0 || rise_bits[8:0] !== 9'h121) begin
      bad++;
      $display("FAIL write_nack: cyc=%0d ack=%b err=%b bits=%h want 144 1 0 121",
               cyc, ack_o, err_o, rise_bits[8:0]);
    end
    s0 = stop_cnt;
    do_cmd(CMD_STOP, 8'h00, cyc);
    total++;
    if (cyc !== 16 || busy_o !== 1'b0 || err_o !== 1'b0 || stop_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL stop: cyc=%0d busy=%b err=%b stops=%0d want 16 0 0 1",
               cyc, busy_o, err_o, stop_cnt - s0);
    end
    total++;
    if ({samp[0], samp[4], samp[8], samp[12]} !== 8'b00101111) begin
      bad++;
      $display("FAIL stop_wave: got %b want 00101111", {samp[0], samp[4], samp[8], samp[12]});
    end
  endtask

  task automatic test_read();
    int cyc;
    do_cmd(CMD_START, 8'h00, cyc);
    slave_en   = 1'b1;
    slave_bits = {8'hA5, 1'b1};
    do_cmd(CMD_READ_ACK, 8'h00, cyc);
    total++;
    if (cyc !== 144 || rx_data_o !== 8'hA5 || rise_bits[0] !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL read_ack: cyc=%0d rx=%h bit9=%b err=%b want 144 a5 0 0",
               cyc, rx_data_o, rise_bits[0], err_o);
    end
    slave_bits = {8'h3C, 1'b1};
    do_cmd(CMD_READ_NAK, 8'h00, cyc);
    slave_en = 1'b0;
    total++;
    if (cyc !== 144 || rx_data_o !== 8'h3C || rise_bits[0] !== 1'b1 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL read_nak: cyc=%0d rx=%h bit9=%b busy=%b want 144 3c 1 1",
               cyc, rx_data_o, rise_bits[0], busy_o);
    end
  endtask

  task automatic test_rstart();
    int cyc, s0;
    s0 = start_cnt;
    do_cmd(CMD_START, 8'h00, cyc);
    total++;
    if ({samp[0], samp[4], samp[8], samp[12]} !== 8'b01111000) begin
      bad++;
      $display("FAIL rstart_wave: got %b want 01111000", {samp[0], samp[4], samp[8], samp[12]});
    end
    total++;
    if (cyc !== 16 || busy_o !== 1'b1 || start_cnt - s0 !== 1) begin
      bad++;
      $display("FAIL rstart: cyc=%0d busy=%b starts=%0d want 16 1 1", cyc, busy_o, start_cnt - s0);
    end
  endtask

  task automatic test_arb_lost();
    int cyc;
    force_low = 1'b1;
    do_cmd(CMD_WRITE, 8'hFF, cyc);
    force_low = 1'b0;
    total++;
    if (cyc !== 12 || err_o !== 1'b1 || busy_o !== 1'b0 || {scl_o, sda_o} !== 2'b11) begin
      bad++;
      $display("FAIL arb_lost: cyc=%0d err=%b busy=%b bus=%b want 12 1 0 11",
               cyc, err_o, busy_o, {scl_o, sda_o});
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen_done;
    do_cmd(CMD_START, 8'h00, cyc);
    @(negedge clk_i);
    cmd_i       = CMD_WRITE;
    tx_data_i   = 8'h44;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    repeat (50) @(posedge clk_i);
    #2;
    total++;
    if (scl_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre: scl=%b want 0", scl_o);
    end
    rst_i = 1'b1;
    #1;
    total++;
    if ({scl_o, sda_o, busy_o, done_o} !== 4'b1100) begin
      bad++;
      $display("FAIL mid_reset: got %b want 1100", {scl_o, sda_o, busy_o, done_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    seen_done = 1'b0;
    repeat (200) begin
      @(posedge clk_i);
      #1;
      if (done_o !== 1'b0) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_after: done_seen=%b rdy=%b want 0 1", seen_done, cmd_ready_o);
    end
  endtask

  task automatic test_stretch();
    int cyc, n, want;
`ifdef I2C_CLK_STRETCH_EN
    want = 164;
`else
    want = 144;
`endif
    do_cmd(CMD_START, 8'h00, cyc);
    slave_en   = 1'b1;
    slave_bits = 9'h1FE;
    fork
      do_cmd(CMD_WRITE, 8'h44, cyc);
      begin
        n = 0;
        while (scl_o !== 1'b1 && n < 400) begin
          @(posedge clk_i);
          #1;
          n++;
        end
        // Hold SCL low from the last divider cycle of bit 0 p1 for 20 cycles.
        repeat (3) @(posedge clk_i);
        #1;
        stretch = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        stretch = 1'b0;
      end
    join
    slave_en = 1'b0;
    total++;
    if (cyc !== want || ack_o !== 1'b0 || rise_bits[8:0] !== 9'h088) begin
      bad++;
      $display("FAIL stretch: cyc=%0d ack=%b bits=%h want %0d 0 088",
               cyc, ack_o, rise_bits[8:0], want);
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_write_ack();
    test_write_nack_stop();
    test_read();
    test_rstart();
    test_arb_lost();
    test_reset_mid();
    test_stretch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
- Synthesizable I2C master byte controller; drives the bus toward slave/responder devices such as the team's I2C slave BFM.
- Accepts byte-level commands (START, STOP, WRITE, READ_ACK, READ_NAK) on a valid/ready interface.
- Sequences the command into 4-phase-per-bit SCL/SDA open-drain activity and returns status.
- Sits between a register front-end and the top-level tristate pads.

Parameters:
- QTR_PERIOD, 250, clk_i cycles per quarter SCL period; 250 @100MHz gives 100kHz. Legal range 2..65535.
- I2C_DATA_WIDTH, 8, byte width on the bus.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- cmd_i  in  3  command, encoded as i2c_cmd_t
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  controller can accept a command
- tx_data_i  in  I2C_DATA_WIDTH  byte for WRITE; sampled on accept
- rx_data_o  out  I2C_DATA_WIDTH  byte captured by READ_*
- ack_o  out  1  ACK bit sampled on WRITE (0=ACK, 1=NACK)
- err_o  out  1  illegal command or arbitration lost; valid with done_o
- done_o  out  1  one-cycle pulse, command complete
- busy_o  out  1  bus owned (between START and STOP)
- scl_i  in  1  sampled SCL line
- sda_i  in  1  sampled SDA line
- scl_o  out  1  0 = pull SCL low, 1 = release
- sda_o  out  1  0 = pull SDA low, 1 = release

Behaviour:
- Reset (asynchronous, immediate):
  - scl_o=1, sda_o=1 (bus released).
  - cmd_ready_o=1; done_o, err_o, ack_o, busy_o = 0; rx_data_o=0.
  - FSM goes to IDLE; divider cleared.
- Handshake:
  - A command is accepted on the edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o drops the next cycle and stays low until the edge that asserts done_o; it rises on that same edge.
  - A new command can be accepted on the edge after done_o.
- Phase timing: every phase lasts exactly QTR_PERIOD cycles. Phases are listed below as (SCL,SDA) driven values.
  - START from idle: (1,1)(1,0)(1,0)(0,0). Total 4Q. Sets busy_o=1.
  - START while busy_o=1 (repeated start): (0,1)(1,1)(1,0)(0,0). Total 4Q.
  - STOP: (0,0)(1,0)(1,1)(1,1). Total 4Q. Clears busy_o on done.
  - Bit phases, per bit:
    - p0: SCL=0, SDA set.
    - p1: SCL=1.
    - p2: SCL=1; sda_i sampled at the end of p2.
    - p3: SCL=0.
  - WRITE: 8 data bits MSB first, then an ACK bit with SDA released; ack_o = sampled sda_i. Total 36Q.
  - READ_ACK / READ_NAK: 8 bits with SDA released, sampled MSB first into rx_data_o (updated on done). Then the master drives 0 (ACK) or releases (NAK) on bit 9. Total 36Q.
- done_o asserts on the edge that ends the final phase.
- FSM states: IDLE, START_PH, RSTART_PH, STOP_PH, DATA_BIT, ACK_BIT, DONE.
- Illegal commands complete with err_o=1 one cycle after accept, with no bus activity:
  - WRITE/READ/STOP while busy_o=0.
  - Undefined cmd_i encoding.
- Arbitration lost (WRITE data bits only): SDA released, sda_i=0 sampled at end of p2.
  - Abort: release both lines, busy_o=0, done_o with err_o=1.
  - ACK-bit mismatch is not arbitration.
- Reset mid-command: lines released the same instant; command discarded; no done_o pulse.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: in any phase where scl_o=1, the divider holds at its terminal count until scl_i==1. The phase then completes one cycle after scl_i is seen high. Slave clock stretching extends timing without bound; no timeout.
- Undefined: scl_i is ignored; all phases are fixed at QTR_PERIOD.

Decomposition:
- Add to the shared i2c_types_pkg:
  - i2c_cmd_t enum: CMD_START=0, CMD_STOP=1, CMD_WRITE=2, CMD_READ_ACK=3, CMD_READ_NAK=4.
  - ACK/NACK bit constants.
- One sub-module, i2c_master_bit_ctrl. It owns the quarter-period divider, phase counter, stretch hold, and the SCL/SDA drive per bit/condition. It exposes bit_cmd/bit_valid/bit_done/bit_rx/arb_lost to the byte FSM.

Test Plan (all with QTR_PERIOD=4):
1. START, then WRITE 0x44 to a BFM at address 0x22 that ACKs → SDA bits 0,1,0,0,0,1,0,0 on SCL rises; ack_o=0; done_o exactly 144 cycles after accept; busy_o=1.
2. START, then WRITE 0x90 with no responder (SDA pulled up) → ack_o=1, err_o=0. Then STOP → SDA rises while SCL high; busy_o=0 after 16 cycles.
3. Slave transmits 0xA5 on READ_ACK, then 0x3C on READ_NAK → rx_data_o=0xA5 then 0x3C; SDA=0 on bit 9 of the first read, released on bit 9 of the second.
4. START while busy_o=1 → repeated-start waveform (0,1)(1,1)(1,0)(0,0); the BFM detects a restart; busy_o stays 1.
5. WRITE with busy_o=0 → done_o with err_o=1 one cycle after accept; scl_o/sda_o stay 1. Also force sda_i=0 during a released data bit → err_o=1, bus released.
6. Assert rst_i mid-byte (cycle 50 of a WRITE) → scl_o=sda_o=1 immediately; no done_o; cmd_ready_o=1 after release. Under I2C_CLK_STRETCH_EN, hold scl_i=0 for 20 cycles in p1 → the byte takes 164 cycles.
